// File: rtl/mod_prep_product.sv
`default_nettype none
// ============================================================================
// Module   : mod_prep_product
// Purpose  : Montgomery pre-processing. Computes t = y * 2^WIDTH mod N by
//            iterated modular doubling. The result is the Montgomery-domain
//            operand consumed by the downstream product block.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH   operand/modulus width in bits (internal adders are WIDTH+1 wide)
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      run request, sampled only while idle
//   N       in   WIDTH  modulus (N > 0), latched at start
//   y       in   WIDTH  operand (y < 2N), latched at start
//   t       out  WIDTH  result, held until the next accepted start completes
//   finish  out  1      one-cycle pulse, t valid
//   err     out  1      only with MOD_PREP_CHECK_EN: pulse with finish when
//                       the latched modulus was zero or even (t forced to 0)
// Configuration macro: MOD_PREP_CHECK_EN
// ============================================================================
module mod_prep_product #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] t,
  output logic             finish
`ifdef MOD_PREP_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int             CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_last;

  // Load-time reduction: a single conditional subtract suffices since y < 2N.
  logic [WIDTH:0]   w_y_ext;
  logic [WIDTH:0]   w_n_ext;
  logic [WIDTH:0]   w_y_sub;
  logic [WIDTH-1:0] w_d_load;

  // Doubling and final accumulate, both evaluated one bit wider than the
  // operands so the carry out of 2d or m+d is never lost before comparing.
  logic [WIDTH:0]   w_nr_ext;
  logic [WIDTH:0]   w_d2;
  logic [WIDTH:0]   w_d2_sub;
  logic [WIDTH-1:0] w_d_next;
  logic [WIDTH:0]   w_md;
  logic [WIDTH:0]   w_md_sub;
  logic [WIDTH-1:0] w_m_next;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_count == C_LAST);

  assign w_y_ext  = {1'b0, y};
  assign w_n_ext  = {1'b0, N};
  assign w_y_sub  = w_y_ext - w_n_ext;
  assign w_d_load = (w_y_ext >= w_n_ext) ? w_y_sub[WIDTH-1:0] : y;

  assign w_nr_ext = {1'b0, r_n};
  assign w_d2     = {r_d, 1'b0};
  assign w_d2_sub = w_d2 - w_nr_ext;
  assign w_d_next = (w_d2 >= w_nr_ext) ? w_d2_sub[WIDTH-1:0] : w_d2[WIDTH-1:0];

  assign w_md     = {1'b0, r_m} + {1'b0, r_d};
  assign w_md_sub = w_md - w_nr_ext;
  assign w_m_next = (w_md >= w_nr_ext) ? w_md_sub[WIDTH-1:0] : w_md[WIDTH-1:0];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_CALC;
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath. Iteration i = r_count runs 0..WIDTH; after WIDTH doublings d
  // holds y*2^WIDTH mod N, so m only needs the one add at i == WIDTH.
  // --------------------------------------------------------------------------
`ifdef MOD_PREP_CHECK_EN
  logic r_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bad <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      if (w_accept) begin
        r_bad <= (N == '0) || !N[0];
      end
      if (r_state == S_DONE) begin
        err <= r_bad;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n     <= '0;
      r_d     <= '0;
      r_m     <= '0;
      r_count <= '0;
      t       <= '0;
      finish  <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n     <= N;
            r_d     <= w_d_load;
            r_m     <= '0;
            r_count <= '0;
          end
        end
        S_CALC: begin
          r_d <= w_d_next;
          if (w_last) begin
            r_m <= w_m_next;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_DONE: begin
`ifdef MOD_PREP_CHECK_EN
          t <= r_bad ? '0 : r_m;
`else
          t <= r_m;
`endif
          finish <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_prep_product.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_prep_product
// Purpose  : Scoreboard bench for mod_prep_product at WIDTH=8 and WIDTH=256.
//            Expected t/err/finish-cycle entries are queued when a start is
//            driven and popped when the DUT raises finish.
// Revision : 1.0  initial release
// ============================================================================
module tb_mod_prep_product;

  typedef struct {
    logic [255:0] t;
    logic         err;
    int           cyc;
  } exp_s;

  logic         clk;
  logic         rst_n;
  int           cyc;

  logic         start8;
  logic [7:0]   n8;
  logic [7:0]   y8;
  logic [7:0]   t8;
  logic         fin8;
  logic         err8;

  logic         start256;
  logic [255:0] n256;
  logic [255:0] y256;
  logic [255:0] t256;
  logic         fin256;
  logic         err256;

  exp_s         q8[$];
  exp_s         q256[$];
  exp_s         e8;
  exp_s         e256;
  int           fin8_cnt;
  int           fin256_cnt;

  int           n_checks;
  int           n_errors;

  logic [255:0] nbig;

  mod_prep_product #(.WIDTH(8)) u_dut8 (
`ifdef MOD_PREP_CHECK_EN
    .err    (err8),
`endif
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start8),
    .N      (n8),
    .y      (y8),
    .t      (t8),
    .finish (fin8)
  );

  mod_prep_product #(.WIDTH(256)) u_dut256 (
`ifdef MOD_PREP_CHECK_EN
    .err    (err256),
`endif
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start256),
    .N      (n256),
    .y      (y256),
    .t      (t256),
    .finish (fin256)
  );

`ifndef MOD_PREP_CHECK_EN
  assign err8   = 1'b0;
  assign err256 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [255:0] obs,
                             input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: (y mod N) * 2^w mod N in wide arithmetic.
  function automatic logic [255:0] model(input logic [255:0] n,
                                         input logic [255:0] yv, input int w);
    logic [511:0] p;
    logic [511:0] r;
    p = {256'b0, yv} % {256'b0, n};
    p = p << w;
    r = p % {256'b0, n};
    return r[255:0];
  endfunction

  // Finish monitors
  always @(negedge clk) begin
    if (rst_n && fin8) begin
      fin8_cnt++;
      if (q8.size() == 0) begin
        check_value("fin8_unexpected", 256'd1, 256'd0);
      end else begin
        e8 = q8.pop_front();
        check_value("t8", {248'b0, t8}, e8.t);
        check_value("lat8", 256'(cyc), 256'(e8.cyc));
`ifdef MOD_PREP_CHECK_EN
        check_value("err8", {255'b0, err8}, {255'b0, e8.err});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && fin256) begin
      fin256_cnt++;
      if (q256.size() == 0) begin
        check_value("fin256_unexpected", 256'd1, 256'd0);
      end else begin
        e256 = q256.pop_front();
        check_value("t256", t256, e256.t);
        check_value("lat256", 256'(cyc), 256'(e256.cyc));
`ifdef MOD_PREP_CHECK_EN
        check_value("err256", {255'b0, err256}, {255'b0, e256.err});
`endif
      end
    end
  end

  task automatic wait_empty8(input int budget);
    int n = 0;
    while (q8.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) begin
      check_value("timeout8", 256'(q8.size()), 256'd0);
      q8.delete();
    end
  endtask

  task automatic wait_empty256(input int budget);
    int n = 0;
    while (q256.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q256.size() != 0) begin
      check_value("timeout256", 256'(q256.size()), 256'd0);
      q256.delete();
    end
  endtask

  // Called at a negedge; the accept edge is the next posedge (cyc+1) and
  // finish is observed WIDTH+2 edges after that.
  task automatic run8(input logic [7:0] n, input logic [7:0] yv,
                      input logic [255:0] et, input logic ee);
    exp_s e;
    e.t   = et;
    e.err = ee;
    e.cyc = cyc + 1 + 8 + 2;
    n8 = n;
    y8 = yv;
    start8 = 1'b1;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    n8 = 8'($urandom);
    y8 = 8'($urandom);
    wait_empty8(40);
  endtask

  task automatic run256(input logic [255:0] n, input logic [255:0] yv,
                        input logic [255:0] et);
    exp_s e;
    e.t   = et;
    e.err = 1'b0;
    e.cyc = cyc + 1 + 256 + 2;
    n256 = n;
    y256 = yv;
    start256 = 1'b1;
    q256.push_back(e);
    @(negedge clk);
    start256 = 1'b0;
    n256 = {8{$urandom}};
    y256 = {8{$urandom}};
    wait_empty256(300);
  endtask

  initial begin
    logic [7:0]   rn;
    logic [7:0]   ry;
    logic [255:0] bn;
    logic [255:0] by;
    int           c0;
    int           fc;
    exp_s         e;

    n_checks   = 0;
    n_errors   = 0;
    fin8_cnt   = 0;
    fin256_cnt = 0;
    rst_n      = 1'b0;
    start8     = 1'b0;
    start256   = 1'b0;
    n8         = 8'd13;
    y8         = 8'd5;
    n256       = '0;
    y256       = '0;
    nbig       = '1 - 256'd188;

    repeat (3) @(negedge clk);
    check_value("rst_t8", {248'b0, t8}, 256'd0);
    check_value("rst_fin8", {255'b0, fin8}, 256'd0);
    check_value("rst_t256", t256, 256'd0);
    check_value("rst_fin256", {255'b0, fin256}, 256'd0);
    check_value("rst_err8", {255'b0, err8}, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed WIDTH=8 cases
    run8(8'd13, 8'd5, 256'd6, 1'b0);
    run8(8'd13, 8'd18, 256'd6, 1'b0);
    run8(8'd13, 8'd1, 256'd9, 1'b0);
    run8(8'd13, 8'd0, 256'd0, 1'b0);

    // Random odd moduli, y anywhere below min(2N, 256)
    for (int i = 0; i < 8; i++) begin
      rn = 8'($urandom_range(1, 255)) | 8'd1;
      ry = 8'($urandom_range(0, (2 * int'(rn) - 1 > 255) ? 255 : 2 * int'(rn) - 1));
      run8(rn, ry, model({248'b0, rn}, {248'b0, ry}, 8), 1'b0);
    end

    // Even modulus
`ifdef MOD_PREP_CHECK_EN
    run8(8'd12, 8'd5, 256'd0, 1'b1);
    run8(8'd13, 8'd5, 256'd6, 1'b0);
`else
    run8(8'd12, 8'd5, 256'd8, 1'b0);
`endif

    // start re-pulsed mid-run with changed operands: ignored
    fc = fin8_cnt;
    e.t = 256'd6; e.err = 1'b0; e.cyc = cyc + 11;
    n8 = 8'd13; y8 = 8'd5; start8 = 1'b1;
    q8.push_back(e);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk); start8 = 1'b1; n8 = 8'd7; y8 = 8'd3;
    @(negedge clk); start8 = 1'b0; n8 = 8'd11; y8 = 8'd2;
    wait_empty8(40);
    repeat (15) @(negedge clk);
    check_value("one_finish", 256'(fin8_cnt - fc), 256'd1);

    // start held high: second run accepted right after finish
    fc = fin8_cnt;
    c0 = cyc;
    e.t = 256'd9; e.err = 1'b0; e.cyc = c0 + 11;
    q8.push_back(e);
    e.t = model(256'd11, 256'd4, 8); e.err = 1'b0; e.cyc = c0 + 22;
    q8.push_back(e);
    n8 = 8'd13; y8 = 8'd1; start8 = 1'b1;
    @(negedge clk); n8 = 8'd11; y8 = 8'd4;
    repeat (14) @(negedge clk);
    start8 = 1'b0;
    wait_empty8(40);
    repeat (15) @(negedge clk);
    check_value("held_finishes", 256'(fin8_cnt - fc), 256'd2);

    // WIDTH=256
    run256(nbig, 256'd1, 256'd189);
    run256(nbig, nbig - 256'd1, nbig - 256'd189);
    for (int i = 0; i < 2; i++) begin
      bn = {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
      bn[255] = 1'b1;
      bn[0]   = 1'b1;
      by = {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
      run256(bn, by, model(bn, by, 256));
    end

    // Asynchronous reset mid-calculation
    run8(8'd13, 8'd1, 256'd9, 1'b0);
    n8 = 8'd13; y8 = 8'd5; start8 = 1'b1;
    n256 = nbig; y256 = 256'd2; start256 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; start256 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_value("arst_t8", {248'b0, t8}, 256'd0);
    check_value("arst_fin8", {255'b0, fin8}, 256'd0);
    check_value("arst_t256", t256, 256'd0);
    check_value("arst_fin256", {255'b0, fin256}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run8(8'd13, 8'd5, 256'd6, 1'b0);
    run256(nbig, 256'd1, 256'd189);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
